// File: rtl/mul_seq.sv
// mul_seq: iterative multiplier sequencer around an external 4x4 nibble
// multiplier (mul2). It walks every nibble pair of the captured operands. Each
// shifted 8-bit partial product is added into a 2*W-bit product register.
//
// Parameters:
//   NIBBLES  operand width in nibbles (1..4); W = 4*NIBBLES
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    request pulse, accepted in IDLE or DONE
//   op_a     multiplicand (W bits), captured on an accepted start
//   op_b     multiplier (W bits), captured on an accepted start
//   acc      accumulate request, sampled with start
//   busy     high while the partial products are being accumulated (RUN)
//   done     one-cycle completion pulse (DONE)
//   product  2*W-bit result register, holds its value until the next start
//   mp_a     nibble driven to mul2 A inputs (0 outside RUN)
//   mp_b     nibble driven to mul2 B inputs (0 outside RUN)
//   mp_r     mul2 product of mp_a*mp_b, combinational
//
// Build option:
//   MULSEQ_ACC_EN  when defined, a start with acc=1 keeps the old product and
//                  adds op_a*op_b to it modulo 2^(2*W). When undefined, acc is
//                  ignored and every start clears the product.
module mul_seq #(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   acc,
    output logic                   busy,
    output logic                   done,
    output logic [8*NIBBLES-1:0]   product,
    output logic [3:0]             mp_a,
    output logic [3:0]             mp_b,
    input  logic [7:0]             mp_r
);

    localparam int W  = 4 * NIBBLES;
    localparam int PW = 2 * W;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int SW = IW + 3;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    // The partial-product index k is held as its two digits: i = k mod NIBBLES
    // and j = k div NIBBLES. This avoids a divider.
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;
    logic [PW-1:0]   product_q, product_d;

    logic            keep;
    logic [SW-1:0]   sh;
    logic [PW-1:0]   pp;

`ifdef MULSEQ_ACC_EN
    assign keep = acc;
`else
    logic acc_unused;
    assign acc_unused = acc;
    assign keep       = 1'b0;
`endif

    // Nibble selects feeding mul2 are held at zero outside RUN.
    always_comb begin
        mp_a = '0;
        mp_b = '0;
        if (state_q == RUN) begin
            mp_a = a_q[4*i_q +: 4];
            mp_b = b_q[4*j_q +: 4];
        end
    end

    // The partial product has weight 16^(i+j). Bits above 2*W are discarded.
    always_comb begin
        sh = (SW'(i_q) + SW'(j_q)) << 2;
        pp = PW'(mp_r) << sh;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        i_d       = i_q;
        j_d       = j_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                    if (!keep) begin
                        product_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                product_d = product_q + pp;
                if (i_q == LAST) begin
                    i_d = '0;
                    j_d = j_q + 1'b1;
                    if (j_q == LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            i_q       <= i_d;
            j_q       <= j_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative multi-nibble multiplier sequencer that sits directly around the 4x4 combinational partial-product multiplier (mul2).
- Drives mul2's A/B nibble inputs and consumes its 8-bit R product.
- Accumulates shifted partial products into a 2*W-bit result, giving the 4-bit datapath 8x8 (or wider) multiply without extra multiplier area.
- Sits between the ALU operand registers and the ALU result writeback.

Parameters:
- NIBBLES, 2, operand width in nibbles; W = 4*NIBBLES. Legal values 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request pulse; sampled each rising edge.
- op_a  input  W  multiplicand; captured when start is accepted.
- op_b  input  W  multiplier; captured when start is accepted.
- acc  input  1  accumulate request; captured with start. Used only when MULSEQ_ACC_EN is defined, otherwise ignored.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- product  output  2*W  result register.
- mp_a  output  4  nibble to mul2 A3..A0.
- mp_b  output  4  nibble to mul2 B3..B0.
- mp_r  input  8  mul2 R7..R0; must equal mp_a*mp_b combinationally within the same cycle.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE, busy=0, done=0, product=0.
  - Captured operands=0, index k=0.
  - mp_a=mp_b=0.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Capture op_a/op_b (and acc).
  - Clear product to 0, unless accumulate mode applies.
  - k=0, go to RUN.
- DONE with start=0: go to IDLE. done is high only in DONE, so it lasts exactly one cycle.
- RUN, partial-product order:
  - Partial product k uses i = k mod NIBBLES and j = k div NIBBLES, for k = 0..NIBBLES^2-1.
  - mp_a = a[4i+3:4i], mp_b = b[4j+3:4j]; both are combinational from the captured registers and k.
- RUN, each rising edge:
  - product <= product + (mp_r << 4*(i+j)), computed at width 2*W; bits above 2*W are discarded.
  - k <= k+1.
  - On the edge that accumulates k = NIBBLES^2-1, go to DONE.
- Latency: done is high in the cycle after the NIBBLES^2-th rising edge following the start-accepting edge. That is 4 edges for NIBBLES=2 and 1 edge for NIBBLES=1.
- Outside RUN: mp_a=mp_b=0.
- busy = (state==RUN).
- start while in RUN is ignored: no capture, no restart, no error.
- product:
  - Holds its final value from DONE until the next accepted start.
  - Intermediate values are visible during RUN and are not guaranteed meaningful to consumers.
- Unsigned arithmetic only. Without accumulate mode the true product always fits in 2*W bits, so no overflow can occur.
- Back-to-back operation: start sampled in DONE begins the next operation with no idle cycle. done still pulses for that one cycle.

Optional Feature:
- Macro: MULSEQ_ACC_EN.
- Defined: when start is accepted with acc=1, product is NOT cleared. The new result is old product + op_a*op_b, modulo 2^(2*W), giving a multiply-accumulate (MAC). Carry-out is discarded; there is no overflow flag. acc=0 behaves as a plain multiply.
- Undefined: the acc port exists but is ignored; product is always cleared on start.

Test Plan:
The bench instantiates mul2 on the mp_* ports; NIBBLES=2 unless noted.
- Reset then op_a=0x00, op_b=0x00, start -> done pulse 4 edges after the start edge, product=0x0000, busy high for exactly 4 cycles.
- op_a=0xFF, op_b=0xFF -> product=0xFE01. In RUN the mp_a/mp_b sequence is (F,F) four times. done is a single cycle and product holds after it.
- op_a=0x12, op_b=0x34 -> product=0x03A8. Additionally, start with op_a=0x99 asserted in the second RUN cycle is ignored and the result is still 0x03A8.
- rst asserted asynchronously mid-RUN (after 2 edges) -> immediately busy=0, done=0, product=0x0000, mp_a=mp_b=0. A new start 0x0A*0x0B then gives 0x006E.
- NIBBLES=1: op_a=0xF, op_b=0xF -> product=0xE1, done 1 edge after the start edge. Back-to-back start in DONE with 0x3*0x5 -> 0x0F.
- MULSEQ_ACC_EN: 0xFF*0xFF (acc=0) -> 0xFE01; then 0x02*0x03 (acc=1) -> 0xFE07; then 0xFF*0xFF (acc=1) -> 0xFC08 (wraps mod 2^16). Without the macro the last step gives 0xFE01.
